// File: rtl/conf_nports_lite_if.sv
// AXI4-Lite slave bus bundle for conf_nports_lite.
// The master modport is the PS side; the slave modport is the register file.
interface conf_nports_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/conf_nports_lite.sv
// Multi-channel AXI4-Lite config register file with per-channel start/busy/done.
// Optional macro CONF_IRQ_MASK_EN adds an IRQ mask (idx 1022) and W1C sticky done bits (idx 1021).
module conf_nports_lite #(
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int unsigned NCH       = 2,
  parameter int unsigned NREG      = 4,
  parameter int unsigned W         = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  conf_nports_lite_if.slave       s_axi,
  output logic [NCH-1:0]          CONFIG_VALID,
  input  logic [NCH-1:0]          CONFIG_READY,
  input  logic [NCH-1:0]          CONFIG_DONE,
  output logic [NCH*NREG*W-1:0]   CONFIG_DATA,
  output logic [NCH-1:0]          CONFIG_IRQ
);

  localparam int unsigned NB      = W / 8;
  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b10;
  localparam logic [9:0] IDX_STATUS = 10'd1023;
`ifdef CONF_IRQ_MASK_EN
  localparam logic [9:0] IDX_MASK   = 10'd1022;
  localparam logic [9:0] IDX_DONE   = 10'd1021;
`endif

  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} wstate_t;

  logic           alive;
  logic [NCH-1:0] busy;
  logic [W-1:0]   cnt [NCH];
`ifdef CONF_IRQ_MASK_EN
  logic [NCH-1:0] irq_mask;
  logic [NCH-1:0] done_sticky;
`endif

  // Word decode: outside the 4 KB window, past the last channel or past the last register.
  function automatic logic addr_bad(input logic [31:0] a);
    logic [9:0] idx;
    idx = a[11:2];
    if (a[31:12] != ADDR_BASE[31:12]) return 1'b1;
    if (idx == IDX_STATUS) return 1'b0;
`ifdef CONF_IRQ_MASK_EN
    if (idx == IDX_MASK || idx == IDX_DONE) return 1'b0;
`endif
    if (idx[9:6] >= 4'(NCH)) return 1'b1;
    if ({1'b0, idx[5:0]} >= 7'(NREG)) return 1'b1;
    return 1'b0;
  endfunction

  // Readies stay low until the first cycle after reset release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  // ---------------- read channel ----------------
  rstate_t      rstate, rstate_nxt;
  logic [9:0]   rd_idx;
  logic         rd_hs;
  logic         rd_bad_c;
  logic [W-1:0] rd_data_c;

  assign rd_idx        = s_axi.araddr[11:2];
  assign s_axi.arready = alive && (rstate == R_IDLE);
  assign s_axi.rvalid  = (rstate == R_DATA);
  assign rd_hs         = s_axi.arvalid && s_axi.arready;

  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (rd_hs) rstate_nxt = R_DATA;
      R_DATA:  if (s_axi.rready) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // Reg 0 of a channel reads back its busy-cycle counter.
  always_comb begin
    rd_bad_c  = addr_bad(s_axi.araddr);
    rd_data_c = '0;
    if (!rd_bad_c) begin
      if (rd_idx == IDX_STATUS) rd_data_c = W'(busy);
`ifdef CONF_IRQ_MASK_EN
      else if (rd_idx == IDX_MASK) rd_data_c = W'(irq_mask);
      else if (rd_idx == IDX_DONE) rd_data_c = W'(done_sticky);
`endif
      else begin
        for (int ch = 0; ch < NCH; ch++) begin
          for (int rr = 0; rr < NREG; rr++) begin
            if (rd_idx[9:6] == 4'(ch) && rd_idx[5:0] == 6'(rr))
              rd_data_c = (rr == 0) ? cnt[ch] : CONFIG_DATA[(ch*NREG+rr)*W +: W];
          end
        end
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate      <= R_IDLE;
      s_axi.rdata <= '0;
      s_axi.rresp <= RESP_OK;
    end else begin
      rstate <= rstate_nxt;
      if (rd_hs) begin
        s_axi.rdata <= rd_data_c;
        s_axi.rresp <= rd_bad_c ? RESP_ERR : RESP_OK;
      end
    end
  end

  // ---------------- write channel ----------------
  wstate_t        wstate, wstate_nxt;
  logic           aw_got, w_got;
  logic [31:0]    awaddr_q;
  logic [W-1:0]   wdata_q;
  logic [NB-1:0]  wstrb_q;
  logic [1:0]     bresp_q;
  logic [9:0]     wr_idx;
  logic           aw_hs, w_hs, commit_c, wr_blocked_c, wr_ok_c;

  assign s_axi.awready = alive && !aw_got && (wstate != W_RESP);
  assign s_axi.wready  = alive && !w_got  && (wstate != W_RESP);
  assign s_axi.bvalid  = (wstate == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign aw_hs         = s_axi.awvalid && s_axi.awready;
  assign w_hs          = s_axi.wvalid  && s_axi.wready;
  assign wr_idx        = awaddr_q[11:2];
  assign commit_c      = (wstate == W_COLLECT) && aw_got && w_got;

  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE:    if (aw_hs || w_hs) wstate_nxt = W_COLLECT;
      W_COLLECT: if (aw_got && w_got) wstate_nxt = W_RESP;
      W_RESP:    if (s_axi.bready) wstate_nxt = W_IDLE;
      default:   wstate_nxt = W_IDLE;
    endcase
  end

  // A channel with a pending start or a running job rejects all writes.
  always_comb begin
    wr_blocked_c = 1'b0;
    for (int ch = 0; ch < NCH; ch++)
      if (wr_idx[9:6] == 4'(ch) && (CONFIG_VALID[ch] || busy[ch])) wr_blocked_c = 1'b1;
    wr_ok_c = commit_c && !addr_bad(awaddr_q) && !wr_blocked_c && (wr_idx != IDX_STATUS);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate   <= W_IDLE;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OK;
    end else begin
      wstate <= wstate_nxt;
      if (aw_hs) begin
        aw_got   <= 1'b1;
        awaddr_q <= s_axi.awaddr;
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (commit_c) begin
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
        bresp_q <= wr_ok_c ? RESP_OK : RESP_ERR;
      end
    end
  end

  // ---------------- channel registers, start handshake, busy counter ----------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      CONFIG_DATA  <= '0;
      CONFIG_VALID <= '0;
      busy         <= '0;
      for (int ch = 0; ch < NCH; ch++) cnt[ch] <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        // A new handshake beats a coincident DONE.
        if (CONFIG_VALID[ch] && CONFIG_READY[ch]) begin
          CONFIG_VALID[ch] <= 1'b0;
          busy[ch]         <= 1'b1;
          cnt[ch]          <= '0;
        end else if (CONFIG_DONE[ch]) begin
          busy[ch] <= 1'b0;
        end else if (busy[ch] && cnt[ch] != '1) begin
          cnt[ch] <= cnt[ch] + W'(1);
        end
      end
      if (wr_ok_c) begin
        for (int ch = 0; ch < NCH; ch++) begin
          for (int rr = 0; rr < NREG; rr++) begin
            if (wr_idx[9:6] == 4'(ch) && wr_idx[5:0] == 6'(rr)) begin
              for (int b = 0; b < NB; b++)
                if (wstrb_q[b]) CONFIG_DATA[(ch*NREG+rr)*W + b*8 +: 8] <= wdata_q[b*8 +: 8];
              if (rr == 0) CONFIG_VALID[ch] <= 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef CONF_IRQ_MASK_EN
  // Sticky done wins over a coincident W1C clear so no completion is lost.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      irq_mask    <= '0;
      done_sticky <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_ok_c && wr_idx == IDX_MASK && wstrb_q[i/8]) irq_mask[i] <= wdata_q[i];
        done_sticky[i] <= CONFIG_DONE[i] |
          (done_sticky[i] & ~(wr_ok_c && wr_idx == IDX_DONE && wstrb_q[i/8] && wdata_q[i]));
      end
    end
  end

  assign CONFIG_IRQ = done_sticky & irq_mask;
`else
  assign CONFIG_IRQ = ~busy & ~CONFIG_VALID;
`endif

endmodule
